// File: rtl/bresenham_pixel_gen_pkg.sv
// Shared types and constants for the Bresenham pixel generator.
package bresenham_pixel_gen_pkg;

    // Default coordinate/delta width (signed two's complement).
    localparam int unsigned DefWidth = 10;

    // Error accumulator needs one extra bit so err - dy cannot overflow.
    function automatic int unsigned err_width(input int unsigned w);
        return w + 1;
    endfunction

    // Line walker state encoding.
    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Minor-axis step encodings supplied by the setup stage.
    localparam logic [DefWidth-1:0] YSTEP_POS = 10'h001;
    localparam logic [DefWidth-1:0] YSTEP_NEG = 10'h3FF;

endpackage

// File: rtl/bresenham_err_step.sv
// One Bresenham inner-loop step: update the error term and the minor-axis coordinate.
module bresenham_err_step
    import bresenham_pixel_gen_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned ERR_W = err_width(WIDTH)
) (
    input  logic [ERR_W-1:0] err_i,
    input  logic [WIDTH-1:0] dy_i,
    input  logic [WIDTH-1:0] dx_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] ystep_i,
    output logic [ERR_W-1:0] err_next_o,
    output logic [WIDTH-1:0] y_next_o
);

    logic [ERR_W-1:0] e1;

    // Subtract dy; on a negative result take a minor-axis step and add dx back.
    always_comb begin
        e1         = err_i - ERR_W'(dy_i);
        err_next_o = e1;
        y_next_o   = y_i;
        if (e1[ERR_W-1]) begin
            err_next_o = e1 + ERR_W'(dx_i);
            // ystep is +1 or -1 in two's complement, so y wraps modulo 2^WIDTH.
            y_next_o   = y_i + ystep_i;
        end
    end

endmodule

// File: rtl/bresenham_pixel_gen.sv
// Bresenham line walker: takes one precomputed parameter set per line and emits
// one screen-space pixel per accepted output handshake.
module bresenham_pixel_gen
    import bresenham_pixel_gen_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned ERR_W = err_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic             steep,
    input  logic [WIDTH-1:0] deltax,
    input  logic [WIDTH-1:0] deltay,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] ystep,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [WIDTH-1:0] pix_x,
    output logic [WIDTH-1:0] pix_y,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [ERR_W-1:0] err_q;
    logic [WIDTH-1:0] x_end_q;
    logic [WIDTH-1:0] dx_q;
    logic [WIDTH-1:0] dy_q;
    logic [WIDTH-1:0] ystep_q;
    logic             steep_q;
    logic             pix_valid_q;
    logic [WIDTH-1:0] pix_x_q;
    logic [WIDTH-1:0] pix_y_q;
    logic             done_q;

    logic [ERR_W-1:0] err_next;
    logic [WIDTH-1:0] y_next;
    logic [WIDTH-1:0] x_inc;

    bresenham_err_step #(
        .WIDTH (WIDTH),
        .ERR_W (ERR_W)
    ) u_err_step (
        .err_i      (err_q),
        .dy_i       (dy_q),
        .dx_i       (dx_q),
        .y_i        (y_q),
        .ystep_i    (ystep_q),
        .err_next_o (err_next),
        .y_next_o   (y_next)
    );

    // Major-axis coordinate of the next pixel.
    always_comb begin
        x_inc = x_q + WIDTH'(1);
    end

    // Line FSM: parameter load, per-pixel advance under backpressure, done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            err_q       <= '0;
            x_end_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            ystep_q     <= '0;
            steep_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q     <= StRun;
                        x_q         <= x0;
                        y_q         <= y0;
                        err_q       <= ERR_W'(deltax >> 1);
                        x_end_q     <= x1;
                        dx_q        <= deltax;
                        dy_q        <= deltay;
                        ystep_q     <= ystep;
                        steep_q     <= steep;
                        pix_valid_q <= 1'b1;
                        // Undo the steep swap so the outputs are true screen (x,y).
                        pix_x_q     <= steep ? y0 : x0;
                        pix_y_q     <= steep ? x0 : y0;
                    end
                end
                StRun: begin
                    // Everything holds while the pixel is not accepted.
                    if (pix_ready) begin
                        if (x_q == x_end_q) begin
                            state_q     <= StIdle;
                            pix_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            x_q     <= x_inc;
                            y_q     <= y_next;
                            err_q   <= err_next;
                            pix_x_q <= steep_q ? y_next : x_inc;
                            pix_y_q <= steep_q ? x_inc : y_next;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    pix_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs derive directly from registered state.
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StRun);
        pix_valid = pix_valid_q;
        pix_x     = pix_x_q;
        pix_y     = pix_y_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_bresenham_pixel_gen.sv
// Directed bench for bresenham_pixel_gen with an expected-pixel scoreboard.
module tb_bresenham_pixel_gen;
    import bresenham_pixel_gen_pkg::*;

    localparam int unsigned W = DefWidth;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x0, x1, deltax, deltay, y0, ystep;
    logic         steep;
    logic         pix_valid;
    logic         pix_ready;
    logic [W-1:0] pix_x, pix_y;
    logic         busy;
    logic         done;

    int checks;
    int passed;
    logic [2*W-1:0] exp_q[$];

    bresenham_pixel_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .steep     (steep),
        .deltax    (deltax),
        .deltay    (deltay),
        .y0        (y0),
        .ystep     (ystep),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic push_pix(input int px, input int py);
        exp_q.push_back({W'(px), W'(py)});
    endtask

    // Called just after a negedge: inputs for the coming posedge are already set.
    // Score the handshake that will occur, then advance to the next negedge.
    task automatic cyc();
        logic [2*W-1:0] e;
        if (pix_valid && pix_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pixel", 32'({pix_x, pix_y}), 32'(e));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_line(input int ax0, input int ax1, input logic ast, input int adx,
                            input int ady, input int ay0, input logic [W-1:0] ays);
        x0 = W'(ax0); x1 = W'(ax1); steep = ast; deltax = W'(adx);
        deltay = W'(ady); y0 = W'(ay0); ystep = ays;
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    int n;

    initial begin
        checks = 0; passed = 0;
        rst = 1'b0; in_valid = 1'b0; pix_ready = 1'b1;
        set_line(0, 0, 1'b0, 0, 0, 0, YSTEP_POS);
        #2;
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_pix_xy", 32'({pix_x, pix_y}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Shallow line
        set_line(0, 4, 1'b0, 4, 2, 0, YSTEP_POS);
        push_pix(0, 0); push_pix(1, 0); push_pix(2, 1); push_pix(3, 1); push_pix(4, 2);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("shallow_first_valid", 32'(pix_valid), 1);
        chk("shallow_busy", 32'(busy), 1);
        chk("shallow_in_ready_low", 32'(in_ready), 0);
        wait_done("shallow_done", 20, n);
        chk("shallow_cycles", 32'(n), 5);
        chk("shallow_ready_with_done", 32'(in_ready), 1);
        chk("shallow_valid_low", 32'(pix_valid), 0);
        cyc();
        chk("shallow_done_pulse", 32'(done), 0);
        chk("shallow_sb_empty", 32'(exp_q.size()), 0);

        // Steep, negative ystep
        set_line(0, 2, 1'b1, 2, 1, 5, YSTEP_NEG);
        push_pix(5, 0); push_pix(5, 1); push_pix(4, 2);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        wait_done("steep_done", 20, n);
        chk("steep_cycles", 32'(n), 3);
        cyc();
        chk("steep_sb_empty", 32'(exp_q.size()), 0);

        // Backpressure at the second pixel
        set_line(0, 4, 1'b0, 4, 2, 0, YSTEP_POS);
        push_pix(0, 0); push_pix(1, 0); push_pix(2, 1); push_pix(3, 1); push_pix(4, 2);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_xy", 32'({pix_x, pix_y}), 32'({W'(1), W'(0)}));
            chk("bp_hold_valid", 32'(pix_valid), 1);
            cyc();
        end
        chk("bp_hold_xy4", 32'({pix_x, pix_y}), 32'({W'(1), W'(0)}));
        pix_ready = 1'b1;
        wait_done("bp_done", 20, n);
        chk("bp_cycles", 32'(n), 4);
        cyc();
        chk("bp_sb_empty", 32'(exp_q.size()), 0);

        // Single point, with a different line offered during RUN
        set_line(7, 7, 1'b0, 0, 0, 3, YSTEP_POS);
        push_pix(7, 3);
        in_valid = 1'b1;
        cyc();
        set_line(100, 120, 1'b1, 20, 5, 50, YSTEP_NEG);
        pix_ready = 1'b0;
        cyc();
        chk("single_hold_xy", 32'({pix_x, pix_y}), 32'({W'(7), W'(3)}));
        pix_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("single_done", 32'(done), 1);
        cyc();
        chk("single_no_relatch", 32'(pix_valid), 0);
        chk("single_idle", 32'(busy), 0);
        chk("single_sb_empty", 32'(exp_q.size()), 0);

        // Horizontal line, then back-to-back shallow line during the done cycle
        set_line(10, 13, 1'b0, 3, 0, 9, YSTEP_POS);
        push_pix(10, 9); push_pix(11, 9); push_pix(12, 9); push_pix(13, 9);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        wait_done("horiz_done", 20, n);
        chk("horiz_cycles", 32'(n), 4);
        chk("horiz_ready_with_done", 32'(in_ready), 1);
        set_line(0, 4, 1'b0, 4, 2, 0, YSTEP_POS);
        push_pix(0, 0); push_pix(1, 0); push_pix(2, 1); push_pix(3, 1); push_pix(4, 2);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("b2b_first_valid", 32'(pix_valid), 1);
        wait_done("b2b_done", 20, n);
        chk("b2b_cycles", 32'(n), 5);
        cyc();
        chk("b2b_sb_empty", 32'(exp_q.size()), 0);

        // Reset mid-line after two pixels accepted
        set_line(0, 4, 1'b0, 4, 2, 0, YSTEP_POS);
        push_pix(0, 0); push_pix(1, 0);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_valid", 32'(pix_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_xy", 32'({pix_x, pix_y}), 0);
        chk("mrst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("mrst_no_done", 32'(done), 0);
        chk("mrst_ready", 32'(in_ready), 1);
        chk("mrst_sb_empty", 32'(exp_q.size()), 0);
        set_line(0, 2, 1'b1, 2, 1, 5, YSTEP_NEG);
        push_pix(5, 0); push_pix(5, 1); push_pix(4, 2);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        wait_done("post_rst_done", 20, n);
        chk("post_rst_cycles", 32'(n), 3);
        cyc();
        chk("post_rst_sb_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bresenham_pixel_gen.md
Name: bresenham_pixel_gen

Overview:
- Consumer end of the line-setup stage. Accepts one registered parameter set per line: x0, x1, steep, deltax, deltay, y0, ystep.
- Runs the Bresenham inner loop and emits one pixel coordinate per accepted output handshake.
- Sits between the parameter-precompute register stage and the framebuffer write path.
- Undoes the steep swap, so the output coordinates are true screen (x,y).

Parameters:
- WIDTH, 10: coordinate/delta width, signed two's complement.
- ERR_W, WIDTH+1: error accumulator width, signed; the extra bit prevents overflow of err-deltay.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  parameter set present.
- in_ready  out  1  block idle and able to accept parameters.
- x0  in  WIDTH  start major-axis coordinate (x0<=x1 guaranteed upstream).
- x1  in  WIDTH  end major-axis coordinate.
- steep  in  1  1 = major axis is screen y.
- deltax  in  WIDTH  x1-x0, non-negative.
- deltay  in  WIDTH  |y1-y0|, non-negative.
- y0  in  WIDTH  start minor-axis coordinate.
- ystep  in  WIDTH  +1 (10'h001) or -1 (10'h3FF).
- pix_valid  out  1  pix_x/pix_y hold a valid pixel.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x  out  WIDTH  screen x.
- pix_y  out  WIDTH  screen y.
- busy  out  1  line in progress.
- done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - pix_valid=0, pix_x=0, pix_y=0, busy=0, done=0.
  - All internal registers (x, y, err, x_end, dx, dy, ystep, steep) are cleared to 0.
  - Reset mid-line abandons the line immediately; no done pulse.
- States:
  - IDLE: in_ready=1, busy=0, pix_valid=0.
  - RUN: in_ready=0, busy=1, pix_valid=1.
- IDLE to RUN on in_valid=1 at a clock edge. At that edge, latch all inputs and load:
  - x<=x0, y<=y0.
  - err<=zero-extended deltax>>1.
- Latency: the first pixel is visible (pix_valid=1) in the cycle after the parameter handshake.
- Output mapping (registered outputs):
  - steep=0: pix_x=x, pix_y=y.
  - steep=1: pix_x=y, pix_y=x.
- Pixel advance occurs only on pix_valid & pix_ready. Hold rule: while pix_ready=0, pix_x, pix_y, pix_valid and all internal state are frozen.
- On an accepted pixel with x!=x_end:
  - e1 = err - dy (ERR_W signed).
  - If e1<0: y<=y+ystep (mod 2^WIDTH), err<=e1+dx.
  - Else: err<=e1.
  - x<=x+1.
- On an accepted pixel with x==x_end: go to IDLE, pix_valid<=0, done<=1 for exactly one cycle. in_ready is high in the same cycle as done.
- in_valid while in RUN is ignored (no latch, no corruption). Upstream must hold its data until in_ready.
- Degenerate cases:
  - x0==x1: exactly one pixel, then done.
  - deltay=0: y is constant.
  - deltax=0 with x0==x1 is the single-point case.
- Throughput: 1 pixel/clock when pix_ready is held at 1. Back-to-back lines cost 1 idle cycle (the done cycle) between lines.
- Arithmetic: y wraps modulo 2^WIDTH; no saturation. err never exceeds the ERR_W range given the upstream deltax/deltay ranges.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=1'b0, RUN=1'b1;
  - WIDTH default 10 and ERR_W derivation;
  - constants YSTEP_POS=10'h001, YSTEP_NEG=10'h3FF.
- One combinational sub-module, bresenham_err_step:
  - inputs: err, dy, dx, y, ystep;
  - outputs: err_next, y_next;
  - the FSM/handshake top instantiates it.

Test Plan:
- Shallow line: x0=0, x1=4, steep=0, dx=4, dy=2, y0=0, ystep=+1, pix_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2) on 5 consecutive cycles, done pulse the next cycle, in_ready=1 with done.
- Steep, negative ystep: x0=0, x1=2, steep=1, dx=2, dy=1, y0=5, ystep=10'h3FF -> pixels (5,0),(5,1),(4,2).
- Backpressure: repeat the shallow line, pix_ready low 3 cycles at the 2nd pixel -> (1,0) held stable 4 cycles; sequence unchanged; no pixel dropped or duplicated.
- Single point: x0=x1=7, y0=3, steep=0 -> exactly one pixel (7,3), then done; in_valid asserted during RUN for a different line -> ignored.
- Horizontal line: x0=10, x1=13, dy=0, y0=9 -> (10,9)..(13,9); back-to-back second line presented on in_valid during the done cycle -> accepted there, first pixel the following cycle.
- Reset mid-line: drop rst after the 2nd pixel of the shallow line -> pix_valid=0, busy=0, pix_x=pix_y=0 immediately, no done; after release the block accepts a new line normally.
